// File: rtl/imem_loader.sv
// imem_loader: writable instruction memory filled from a big-endian byte stream.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [15:0] load_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [15:0] PC,
  output logic [31:0] Instruction,
  output logic        cpu_run,
  output logic        load_busy,
  output logic        load_err,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] buf_q, buf_d;
  logic [15:0] words_q, words_d;
  logic [15:0] len_q, len_d;
  logic        wr_en;
  logic        len_ok;

  logic [31:0] mem_q [DEPTH];

  assign len_ok = (load_len != 16'd0) && (load_len <= DEPTH_W);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    words_d    = words_q;
    len_d      = len_q;
    wr_en      = 1'b0;
    case (state_q)
      S_LOAD: begin
        // load_start is deliberately ignored while a load is in flight
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: buf_d[23:16] = byte_in;
            2'd1: buf_d[15:8]  = byte_in;
            2'd2: buf_d[7:0]   = byte_in;
            default: begin
              wr_en   = 1'b1;
              words_d = words_q + 16'd1;
              if (words_d == len_q) state_d = S_RUN;
            end
          endcase
        end
      end
      default: begin
        if (load_start) begin
          if (len_ok) begin
            state_d    = S_LOAD;
            words_d    = 16'd0;
            byte_cnt_d = 2'd0;
            len_d      = load_len;
          end else begin
            state_d = S_ERR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      buf_q      <= 24'd0;
      words_q    <= 16'd0;
      len_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      words_q    <= words_d;
      len_q      <= len_d;
    end
  end

  // Array is never reset; words_q gates what the CPU can see.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[words_q[ADDR_W-1:0]] <= {buf_q, byte_in};
  end

  assign byte_ready   = (state_q == S_LOAD);
  assign load_busy    = (state_q == S_LOAD);
  assign cpu_run      = (state_q == S_RUN);
  assign load_err     = (state_q == S_ERR);
  assign words_loaded = words_q;

  // words_q never exceeds DEPTH, so this also rejects PC >= DEPTH
  assign Instruction = ((state_q == S_RUN) && (PC < words_q)) ?
                       mem_q[PC[ADDR_W-1:0]] : 32'h0;

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable instruction memory plus byte-stream loader; the write side of the CPU's instruction store.
- Accepts a program as a stream of bytes over a valid/ready handshake and packs them big-endian into 32-bit words stored in an internal array.
- Holds the CPU idle via `cpu_run` until the load completes.
- Serves fetches combinationally from PC, identical in timing to the fixed instruction memory it replaces.

Parameters:
- DEPTH, 64, number of 32-bit instruction words stored.
- ADDR_W, 6, log2(DEPTH); index width of the word array.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle request to begin a load.
- load_len  input  16  number of words to load; sampled when `load_start`=1.
- byte_in  input  8  program byte.
- byte_valid  input  1  `byte_in` valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- PC  input  16  word address of the instruction to fetch.
- Instruction  output  32  fetched instruction; 0 (NOOP) when not valid.
- cpu_run  output  1  program loaded; CPU may execute.
- load_busy  output  1  load in progress.
- load_err  output  1  last `load_start` had an illegal length.
- words_loaded  output  16  words committed by the current or last load.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE; all outputs 0; byte and word counters 0; partial-word buffer 0.
  - Array contents are not cleared; the `words_loaded` guard hides them.
- States:
  - IDLE, LOAD, RUN, ERR.
  - `byte_ready`=(state==LOAD), combinational from state.
  - `load_busy`=(state==LOAD). `cpu_run`=(state==RUN). `load_err`=(state==ERR).
- IDLE/RUN/ERR + `load_start`=1:
  - If 1<=`load_len`<=DEPTH: next state=LOAD; `words_loaded`<=0; byte_cnt<=0.
  - Otherwise: next state=ERR and `words_loaded` is unchanged.
  - From ERR, a new `load_start` is evaluated the same way, so a second illegal length stays in ERR.
  - Leaving RUN drops `cpu_run` on the next edge.
- LOAD, handshake:
  - A byte is accepted on a rising edge where `byte_valid`&&`byte_ready`.
  - Order within a word is big-endian: byte_cnt 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
- LOAD, word commit:
  - On acceptance with byte_cnt==3, the full word is written to mem[`words_loaded`[ADDR_W-1:0]]; `words_loaded` increments; byte_cnt wraps to 0.
  - If the incremented count equals the latched length, next state=RUN.
  - `byte_ready` is 0 from the following cycle; extra bytes are never accepted.
- LOAD, other inputs:
  - `load_start` during LOAD is ignored.
  - `byte_valid`=0 cycles stall without effect.
- Read path (combinational, no clock):
  - `Instruction` = mem[PC[ADDR_W-1:0]] when state==RUN and PC<`words_loaded`.
  - Otherwise `Instruction`=0, including PC>=DEPTH, PC beyond the loaded length, and any state other than RUN.
  - The read is live in the same cycle PC changes.
- Latency:
  - Last byte accepted at edge N → `cpu_run`=1 after edge N (visible in cycle N+1).
  - A word is readable once in RUN.
- Reset mid-load: the load is discarded; return to IDLE; `words_loaded`=0; partial bytes are lost.
- Length is a word count; `load_len`=DEPTH is legal; DEPTH+1 and 0 are illegal.

Test Plan:
- Reset, no stimulus:
  - Required: `cpu_run`=0, `byte_ready`=0, `load_err`=0, `words_loaded`=0, `Instruction`=0 for PC=0.
- `load_start`, `load_len`=2, bytes E4 21 00 07 48 21 00 00 back-to-back:
  - `byte_ready` high 8 cycles; `cpu_run` rises the cycle after the 8th byte.
  - Reads: PC=0→0xE4210007, PC=1→0x48210000, PC=2→0, PC=0xFFFF→0.
- Same load with `byte_valid` toggled 1,0,0,1,…:
  - Only accepted bytes count; identical memory contents; `words_loaded`=2.
  - A 9th valid byte is not accepted (`byte_ready`=0).
- Length checks:
  - `load_len`=0 → `load_err`=1, `cpu_run`=0.
  - `load_len`=65 → stays ERR.
  - `load_len`=64 with 256 bytes → RUN, `words_loaded`=64, PC=63 returns the last word.
- Reset mid-load:
  - `rst_n` pulsed low after 5 bytes of a 2-word load → IDLE; `words_loaded`=0; `Instruction`=0.
  - A subsequent full 1-word load works.
- Reload from RUN:
  - After the 2-word program, `load_start` with `load_len`=1 → `cpu_run` drops the next cycle.
  - After 4 bytes 00 00 00 01: PC=0→0x00000001, PC=1→0 (stale word hidden).
